instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 26 ++
 rtl/instr_encoder_if.sv | 38 +++
 rtl/instr_pack.sv | 27 ++
 rtl/instr_encoder.sv | 114 +++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared CPU instruction-format definitions used by both the encode and decode stages.
package instr_encoder_pkg;

   typedef enum logic [1:0] {
      FMT_R   = 2'b00,
      FMT_I   = 2'b01,
      FMT_J   = 2'b10,
      FMT_BAD = 2'b11
   } fmt_e;

   localparam int FMT_W    = 2;
   localparam int OPCODE_W = 6;
   localparam int REG_W    = 5;
   localparam int SHAMT_W  = 5;
   localparam int FUNCT_W  = 6;
   localparam int IMM_W    = 16;
   localparam int JADDR_W  = 26;
   localparam int INSTR_W  = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_FULL = 2'b10
   } enc_state_e;

endpackage

// File: rtl/instr_encoder_if.sv
// Field-tuple input handshake plus instruction-memory write port of the encoder.
interface instr_encoder_if #(
   parameter int ADDR_W = 8
);
   import instr_encoder_pkg::*;

   logic                in_valid;
   logic                in_ready;
   logic [FMT_W-1:0]    fmt;
   logic [OPCODE_W-1:0] opcode;
   logic [REG_W-1:0]    rs;
   logic [REG_W-1:0]    rt;
   logic [REG_W-1:0]    rd;
   logic [SHAMT_W-1:0]  shamt;
   logic [FUNCT_W-1:0]  funct;
   logic [IMM_W-1:0]    immediate;
   logic [JADDR_W-1:0]  address;

   logic                wr_valid;
   logic                wr_ready;
   logic [ADDR_W-1:0]   wr_addr;
   logic [INSTR_W-1:0]  wr_data;

   modport slave (
      input  in_valid, fmt, opcode, rs, rt, rd, shamt, funct, immediate, address,
      output in_ready,
      output wr_valid, wr_addr, wr_data,
      input  wr_ready
   );

   modport master (
      output in_valid, fmt, opcode, rs, rt, rd, shamt, funct, immediate, address,
      input  in_ready,
      input  wr_valid, wr_addr, wr_data,
      output wr_ready
   );

endinterface

// File: rtl/instr_pack.sv
// Combinational packing of instruction fields into a 32-bit word; zero latency, no flow control.
// FMT_BAD packs as R; whether such a word is written is decided by the encoder.
module instr_pack
   import instr_encoder_pkg::*;
(
   input  fmt_e                fmt,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [REG_W-1:0]    rs,
   input  logic [REG_W-1:0]    rt,
   input  logic [REG_W-1:0]    rd,
   input  logic [SHAMT_W-1:0]  shamt,
   input  logic [FUNCT_W-1:0]  funct,
   input  logic [IMM_W-1:0]    immediate,
   input  logic [JADDR_W-1:0]  address,
   output logic [INSTR_W-1:0]  word
);

   always_comb begin
      word = '0;
      case (fmt)
         FMT_I:   word = {opcode, rs, rt, immediate};
         FMT_J:   word = {opcode, address};
         default: word = {opcode, rs, rt, rd, shamt, funct};
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Encodes field tuples into instruction-memory writes; one-cycle latency, one word/cycle, stalls on wr_ready.
// ENC_FMT_CHECK_EN: illegal fmt is consumed without a write and pulses err; otherwise it encodes as R.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            clear,
   instr_encoder_if.slave  bus,
   output logic            full,
   output logic [ADDR_W:0] count,
   output logic            err
);

   localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + (1 << ADDR_W) - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE   = 1;
   localparam logic [ADDR_W:0]   CNT_ONE    = 1;

   enc_state_e         state_q;
   enc_state_e         state_d;
   logic               wr_valid_q;
   logic [ADDR_W-1:0]  wr_addr_q;
   logic [INSTR_W-1:0] wr_data_q;
   logic [ADDR_W:0]    count_q;
   logic               err_q;
   logic [INSTR_W-1:0] packed_word;
   fmt_e               fmt_in;
   logic               accept;
   logic               fire;
   logic               drop_bad;
   logic               load_word;

   assign fmt_in = fmt_e'(bus.fmt);

   instr_pack u_pack (
      .fmt       (fmt_in),
      .opcode    (bus.opcode),
      .rs        (bus.rs),
      .rt        (bus.rt),
      .rd        (bus.rd),
      .shamt     (bus.shamt),
      .funct     (bus.funct),
      .immediate (bus.immediate),
      .address   (bus.address),
      .word      (packed_word)
   );

   assign bus.in_ready = (state_q == ST_LOAD) && (!wr_valid_q || bus.wr_ready);
   assign accept       = bus.in_valid && bus.in_ready;
   assign fire         = wr_valid_q && bus.wr_ready;

`ifdef ENC_FMT_CHECK_EN
   assign drop_bad = (fmt_in == FMT_BAD);
`else
   assign drop_bad = 1'b0;
`endif

   assign load_word = accept && !drop_bad;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_LOAD;
         ST_LOAD: if (fire && (wr_addr_q == LAST_ADDR)) state_d = ST_FULL;
         ST_FULL: state_d = ST_FULL;
         default: state_d = ST_IDLE;
      endcase
      if (clear) state_d = ST_LOAD;
   end

   // Clear wins over any same-cycle accept or fire, so the pending word is simply dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= FIRST_ADDR;
         wr_data_q  <= '0;
         count_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= accept && drop_bad && !clear;
         if (clear) begin
            wr_valid_q <= 1'b0;
            wr_addr_q  <= FIRST_ADDR;
            count_q    <= '0;
         end else begin
            if (fire) begin
               wr_addr_q <= wr_addr_q + ADDR_ONE;
               count_q   <= count_q + CNT_ONE;
            end
            if (load_word) begin
               wr_valid_q <= 1'b1;
               wr_data_q  <= packed_word;
            end else if (fire) begin
               wr_valid_q <= 1'b0;
            end
         end
      end
   end

   assign bus.wr_valid = wr_valid_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;
   assign full         = (state_q == ST_FULL);
   assign count        = count_q;
   assign err          = err_q;

endmodule
